// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the MIPS instruction encoder/loader and the
// opcode decoder.
//   - op_sel operation-class codes carried on the loader's input bus
//   - 6-bit primary opcodes of the supported instructions
//   - loader FSM state encoding
package mips_pkg;

    // Operation classes on op_sel; codes 9..15 are illegal.
    localparam logic [3:0] OPS_RTYPE = 4'd0;
    localparam logic [3:0] OPS_ADDI  = 4'd1;
    localparam logic [3:0] OPS_ANDI  = 4'd2;
    localparam logic [3:0] OPS_ORI   = 4'd3;
    localparam logic [3:0] OPS_LW    = 4'd4;
    localparam logic [3:0] OPS_SW    = 4'd5;
    localparam logic [3:0] OPS_BEQ   = 4'd6;
    localparam logic [3:0] OPS_LH    = 4'd7;
    localparam logic [3:0] OPS_LHU   = 4'd8;

    // Primary opcode field, instruction bits [31:26].
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_LH    = 6'b100001;
    localparam logic [5:0] OPC_LHU   = 6'b100101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: instruction-input handshake plus the
// instruction-memory write port of the loader.
//
// Handshake: a beat transfers on a rising edge where in_valid and in_ready
// are both high. in_ready is a registered output of the loader that depends
// only on its state; the producer holds the fields and in_last stable while
// in_valid is high and in_ready is low.
//
//   master (producer / memory side): drives in_valid, in_last, op_sel, rs,
//     rt, rd, funct, imm; observes in_ready, mem_we, mem_addr, mem_wdata.
//   slave (loader): the reverse.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        op_sel;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_last, op_sel, rs, rt, rd, funct, imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_last, op_sel, rs, rt, rd, funct, imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encode.sv
// instr_encode: combinational MIPS instruction assembler.
//   op_sel, rs, rt, rd, funct, imm in : symbolic instruction fields
//   word                           out: 32-bit encoded instruction (0 if illegal)
//   illegal                        out: op_sel is not a supported class
// I-type words ignore rd and funct.
module instr_encode
    import mips_pkg::*;
(
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);
    logic [5:0] opcode;
    logic       i_type;

    always_comb begin
        opcode  = OPC_RTYPE;
        i_type  = 1'b1;
        illegal = 1'b0;
        word    = 32'd0;
        case (op_sel)
            OPS_RTYPE: i_type = 1'b0;
            OPS_ADDI:  opcode = OPC_ADDI;
            OPS_ANDI:  opcode = OPC_ANDI;
            OPS_ORI:   opcode = OPC_ORI;
            OPS_LW:    opcode = OPC_LW;
            OPS_SW:    opcode = OPC_SW;
            OPS_BEQ:   opcode = OPC_BEQ;
            OPS_LH:    opcode = OPC_LH;
            OPS_LHU:   opcode = OPC_LHU;
            default: begin
                i_type  = 1'b0;
                illegal = 1'b1;
            end
        endcase
        if (i_type) begin
            word = {opcode, rs, rt, imm};
        end else if (!illegal) begin
            word = {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
        end
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts symbolic instructions, encodes them and writes
// them to instruction memory at consecutive word addresses from BASE_ADDR.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : pulse that opens a load session (ignored while loading)
//   bus       : instruction handshake + memory write port (slave side)
//   count     : words written this session
//   busy      : session open (includes the final write cycle)
//   done      : session finished, held until next start
//   full      : session ended by reaching DEPTH words
//   err       : sticky, an illegal op_sel was accepted this session
//   state     : FSM state, for observation
module instr_encoder_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    instr_encoder_loader_if.slave  bus,
    output logic [ADDR_W:0]        count,
    output logic                   busy,
    output logic                   done,
    output logic                   full,
    output logic                   err,
    output state_t                 state
);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [31:0]       word;
    logic              illegal;
    logic              accept;
    logic [ADDR_W-1:0] waddr;      // address the next legal word goes to
    logic              fin_pend;   // final beat accepted, close on next edge
    logic              fin_full;   // that final beat reached DEPTH
    logic [ADDR_W:0]   written_after;
    logic              hits_depth;

    instr_encode u_encode (
        .op_sel  (bus.op_sel),
        .rs      (bus.rs),
        .rt      (bus.rt),
        .rd      (bus.rd),
        .funct   (bus.funct),
        .imm     (bus.imm),
        .word    (word),
        .illegal (illegal)
    );

    assign accept = bus.in_valid & bus.in_ready;

    // count lags accepts by the write cycle, so the word in flight (mem_we)
    // is added when deciding whether this accept is the DEPTH-th one.
    assign written_after = count + (ADDR_W + 1)'(bus.mem_we) + (ADDR_W + 1)'(1);
    assign hits_depth    = !illegal && (written_after == DEPTH_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= BASE;
            bus.mem_wdata <= 32'd0;
            count         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            full          <= 1'b0;
            err           <= 1'b0;
            waddr         <= BASE;
            fin_pend      <= 1'b0;
            fin_full      <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            if (bus.mem_we) begin
                count <= count + 1'b1;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state        <= ST_LOAD;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        full         <= 1'b0;
                        err          <= 1'b0;
                        count        <= '0;
                        waddr        <= BASE;
                    end
                end
                ST_LOAD: begin
                    if (fin_pend) begin
                        // End of the final write cycle (or the illegal last beat).
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        full     <= fin_full;
                        fin_pend <= 1'b0;
                    end else if (accept) begin
                        if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= waddr;
                            bus.mem_wdata <= word;
                            waddr         <= waddr + 1'b1;
                        end
                        if (bus.in_last || hits_depth) begin
                            bus.in_ready <= 1'b0;
                            fin_pend     <= 1'b1;
                            fin_full     <= hits_depth;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader (DEPTH=4, BASE_ADDR=0): directed instruction
// sessions; expected memory writes go into a queue that a negedge monitor
// drains against every mem_we pulse.
module tb_instr_encoder_loader;
    import mips_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [ADDR_W:0] count;
    logic            busy, done, full, err;
    state_t          state;

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) ifc ();

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (ifc),
        .count (count),
        .busy  (busy),
        .done  (done),
        .full  (full),
        .err   (err),
        .state (state)
    );

    // clock
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W-1:0]  exp_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && ifc.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected write addr", 32'(ifc.mem_addr), 32'hFFFF_FFFF);
            end else begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                chk("write addr", 32'(ifc.mem_addr), 32'(e[ADDR_W+31:32]));
                chk("write data", ifc.mem_wdata, e[31:0]);
            end
        end
    end

    // drivers
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = '0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs_v, input logic [4:0] rt_v,
                        input logic [4:0] rd_v, input logic [5:0] fn, input logic [15:0] im,
                        input bit last, input bit expect_write, input logic [31:0] exp_word,
                        input int max_cyc, output bit acc);
        ifc.op_sel = op; ifc.rs = rs_v; ifc.rt = rt_v; ifc.rd = rd_v;
        ifc.funct = fn; ifc.imm = im; ifc.in_last = last; ifc.in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < max_cyc && !acc; i++) begin
            @(negedge clk);
            if (ifc.in_ready === 1'b1) begin
                acc = 1'b1;
                if (expect_write) begin
                    exp_q.push_back({exp_addr, exp_word});
                    exp_addr = exp_addr + 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic send_ok(input logic [3:0] op, input logic [4:0] rs_v, input logic [4:0] rt_v,
                           input logic [4:0] rd_v, input logic [5:0] fn, input logic [15:0] im,
                           input bit last, input bit expect_write, input logic [31:0] exp_word);
        bit acc;
        send(op, rs_v, rt_v, rd_v, fn, im, last, expect_write, exp_word, 8, acc);
        chk("accepted", 32'(acc), 32'd1);
    endtask

    // called right after the final beat is accepted
    task automatic check_end(input int exp_cnt, input bit exp_err, input bit exp_full);
        @(negedge clk);
        chk("final cycle busy", 32'(busy), 32'd1);
        chk("final cycle done", 32'(done), 32'd0);
        chk("final cycle in_ready", 32'(ifc.in_ready), 32'd0);
        @(negedge clk);
        chk("done", 32'(done), 32'd1);
        chk("busy after done", 32'(busy), 32'd0);
        chk("count", 32'(count), 32'(exp_cnt));
        chk("err", 32'(err), 32'(exp_err));
        chk("full", 32'(full), 32'(exp_full));
        chk("in_ready in done", 32'(ifc.in_ready), 32'd0);
        chk("state done", 32'(state), 32'(ST_DONE));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " in_ready"}, 32'(ifc.in_ready), 32'd0);
        chk({tag, " mem_we"}, 32'(ifc.mem_we), 32'd0);
        chk({tag, " mem_addr"}, 32'(ifc.mem_addr), 32'd0);
        chk({tag, " mem_wdata"}, ifc.mem_wdata, 32'd0);
        chk({tag, " count"}, 32'(count), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " full"}, 32'(full), 32'd0);
        chk({tag, " err"}, 32'(err), 32'd0);
        chk({tag, " state"}, 32'(state), 32'(ST_IDLE));
    endtask

    initial begin
        bit acc;
        ifc.in_valid = 1'b0; ifc.in_last = 1'b0; ifc.op_sel = '0;
        ifc.rs = '0; ifc.rt = '0; ifc.rd = '0; ifc.funct = '0; ifc.imm = '0;
        exp_addr = '0;

        // reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;

        // addi $8,$0,5 as a single-word session
        pulse_start();
        send_ok(OPS_ADDI, 5'd0, 5'd8, 5'd31, 6'h3f, 16'd5, 1'b1, 1'b1, 32'h2008_0005);
        check_end(1, 1'b0, 1'b0);

        // add $3,$1,$2 then lw $9,4($29) with last
        pulse_start();
        send_ok(OPS_RTYPE, 5'd1, 5'd2, 5'd3, 6'h20, 16'hABCD, 1'b0, 1'b1, 32'h0022_1820);
        send_ok(OPS_LW, 5'd29, 5'd9, 5'd0, 6'h00, 16'd4, 1'b1, 1'b1, 32'h8FA9_0004);
        check_end(2, 1'b0, 1'b0);

        // in_valid during DONE is ignored
        ifc.in_valid = 1'b1; ifc.op_sel = OPS_ADDI;
        repeat (4) @(posedge clk);
        #1 ifc.in_valid = 1'b0;
        @(negedge clk);
        chk("count held in done", 32'(count), 32'd2);
        chk("done held", 32'(done), 32'd1);

        // illegal op_sel between two legal words
        pulse_start();
        send_ok(OPS_ANDI, 5'd5, 5'd4, 5'd0, 6'h00, 16'h1234, 1'b0, 1'b1, 32'h30A4_1234);
        send_ok(4'd12, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0001, 1'b0, 1'b0, 32'd0);
        send_ok(OPS_ORI, 5'd0, 5'd10, 5'd0, 6'h00, 16'h00FF, 1'b1, 1'b1, 32'h340A_00FF);
        check_end(2, 1'b1, 1'b0);

        // illegal word carrying in_last still closes the session
        pulse_start();
        send_ok(OPS_BEQ, 5'd1, 5'd2, 5'd0, 6'h00, 16'hFFFF, 1'b0, 1'b1, 32'h1022_FFFF);
        send_ok(4'd15, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 1'b1, 1'b0, 32'd0);
        check_end(1, 1'b1, 1'b0);

        // start during LOAD is ignored
        pulse_start();
        send_ok(OPS_SW, 5'd6, 5'd7, 5'd0, 6'h00, 16'd8, 1'b0, 1'b1, 32'hACC7_0008);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_ok(OPS_LH, 5'd4, 5'd3, 5'd0, 6'h00, 16'd2, 1'b1, 1'b1, 32'h8483_0002);
        check_end(2, 1'b0, 1'b0);

        // DEPTH limit: five back-to-back words, no in_last
        pulse_start();
        send_ok(OPS_SW, 5'd6, 5'd7, 5'd0, 6'h00, 16'd8, 1'b0, 1'b1, 32'hACC7_0008);
        send_ok(OPS_BEQ, 5'd1, 5'd2, 5'd0, 6'h00, 16'hFFFF, 1'b0, 1'b1, 32'h1022_FFFF);
        send_ok(OPS_LH, 5'd4, 5'd3, 5'd0, 6'h00, 16'd2, 1'b0, 1'b1, 32'h8483_0002);
        send_ok(OPS_LHU, 5'd4, 5'd3, 5'd0, 6'h00, 16'd2, 1'b0, 1'b1, 32'h9483_0002);
        send(OPS_ANDI, 5'd5, 5'd4, 5'd0, 6'h00, 16'h1234, 1'b0, 1'b1, 32'h30A4_1234, 4, acc);
        chk("fifth word refused", 32'(acc), 32'd0);
        chk("full after depth", 32'(full), 32'd1);
        chk("done after depth", 32'(done), 32'd1);
        chk("count at depth", 32'(count), 32'(DEPTH));

        // reset during the write cycle discards the write
        pulse_start();
        send_ok(OPS_ADDI, 5'd0, 5'd8, 5'd0, 6'h00, 16'd5, 1'b0, 1'b0, 32'd0);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        check_reset_values("mid-session reset");
        @(posedge clk); #1;
        pulse_start();
        send_ok(OPS_ORI, 5'd0, 5'd10, 5'd0, 6'h00, 16'h00FF, 1'b1, 1'b1, 32'h340A_00FF);
        check_end(1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // hard time limit
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential instruction encoder and program loader for the single-cycle MIPS core: the encoding counterpart of the opcode decoder. Accepts symbolic instructions (operation class plus register and immediate fields) over a valid/ready handshake. Assembles each one into a 32-bit MIPS word and writes it into instruction memory at consecutive word addresses. Used by the test harness and the boot path to fill instruction memory before the core is released from reset.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- DEPTH, 256, maximum words per load session (≤ 2^ADDR_W)
- BASE_ADDR, 0, first word address written in each session
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse that opens a load session
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block can accept an instruction this cycle
- in_last  in  1  marks final instruction of the session
- op_sel  in  4  operation class: 0 R-type, 1 addi, 2 andi, 3 ori, 4 lw, 5 sw, 6 beq, 7 lh, 8 lhu, 9–15 illegal
- rs, rt, rd  in  5 each  register fields
- funct  in  6  R-type function field
- imm  in  16  immediate / offset
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written this session
- busy  out  1  session open
- done  out  1  session finished, held until next start
- full  out  1  session ended by reaching DEPTH
- err  out  1  sticky: illegal op_sel accepted this session

## Operation
- Encoding for R-type: {6'b000000, rs, rt, rd, 5'b00000, funct}.
- Encoding for I-type: {opcode, rs, rt, imm}. rd and funct are ignored.
- I-type opcodes: addi 001000, andi 001100, ori 001101, lw 100011, sw 101011, beq 000100, lh 100001, lhu 100101.
- FSM states IDLE, LOAD, DONE. Reset state is IDLE.
- IDLE: on start, go to LOAD, set address to BASE_ADDR, clear count, err, full and done.
- LOAD: in_ready = 1. An accept is in_valid & in_ready.
- Accept with legal op_sel: next cycle drives mem_we=1, mem_addr=current address, mem_wdata=encoded word. Address and count then increment.
- Accept with illegal op_sel: nothing is written; address and count are unchanged; err is set.
- Accept with in_last: go to DONE after that word's write. Applies even if the word is illegal.
- Write that makes count == DEPTH: go to DONE, set full. Any in_last on that beat is redundant.
- DONE: done=1, in_ready=0. A start pulse begins a new session as described for IDLE.
- start while in LOAD is ignored.
- Reset mid-session: immediate return to IDLE with all outputs at reset values. A pending write is discarded.
- Address width: mem_addr wraps modulo 2^ADDR_W. The DEPTH limit normally prevents any wrap.

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, count 0, busy 0, done 0, full 0, err 0.
- Latency is 1 cycle. An accept at edge N produces mem_we high for exactly cycle N+1.
- Throughput is one instruction per cycle while in LOAD.
- busy is high in LOAD, and also during the final write cycle.
- in_ready is 0 from the edge after in_last is accepted, or after the DEPTH-th accept.
- in_ready is registered and depends only on state, not on in_valid.
- The done rise coincides with the cycle after the final mem_we pulse.
- count is updated on the same edge that ends the mem_we cycle.

## Structure
- Shared package mips_pkg holds:
  - the op_sel enumeration constants;
  - the 6-bit opcode constants (shared with the decoder);
  - the FSM state encoding.
- One combinational sub-module, instr_encode: maps (op_sel, rs, rt, rd, funct, imm) to {word, illegal}.
- The top level holds the FSM, the address/count registers and the output register stage.

## Test plan
- addi $8,$0,5 after start: op_sel=1, rs=0, rt=8, imm=5 → mem_wdata 0x20080005 at addr 0, count=1.
- R-type add $3,$1,$2 (funct 0x20), then lw $9,4($29) with in_last → 0x00221820 at 0 and 0x8FA90004 at 1, then done=1, in_ready=0.
- op_sel=12 between two legal words → no write for the illegal beat, second legal word lands at addr 1, err=1.
- DEPTH=4, five back-to-back valid words, no in_last → exactly 4 writes, full=1, done=1, fifth never accepted.
- Reset asserted in the cycle mem_we is high mid-session → all outputs zero/BASE_ADDR next cycle. A new start restarts at BASE_ADDR.
- start pulsed during LOAD and in_valid during DONE → both ignored, no extra writes, count unchanged.
